// File: rtl/wb_uart_rx.sv
// Wishbone-readable UART receiver: 8N1 deserializer feeding a small byte FIFO,
// with sticky overrun / frame-error status and a programmable bit divider.
module wb_uart_rx #(
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     uart_rx_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o
);

    localparam int unsigned     PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW-1:0] PtrLast    = PtrW'(FIFO_DEPTH - 1);
    localparam logic [3:0]      CountFull  = 4'(FIFO_DEPTH);
    localparam logic [31:0]     SanityWord = 32'h0B0BA17E;

    localparam logic [1:0] RegDivider = 2'd0;
    localparam logic [1:0] RegData    = 2'd1;
    localparam logic [1:0] RegStatus  = 2'd2;
    localparam logic [1:0] RegSanity  = 2'd3;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic                     wb_req, wb_rd, wb_wr;
    logic [1:0]               reg_sel;
    logic                     ack_q, ack_d;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]              divider_q, divider_d;
    logic                     overrun_q, overrun_d;
    logic                     frame_err_q, frame_err_d;

    logic [1:0]               sync_q;
    logic                     rx_s;

    state_e                   state_q, state_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [31:0]              bit_end, half_end;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [7:0]               shift_q, shift_d;
    logic                     rx_push, rx_frame_err;

    logic [7:0]               mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]               count_q, count_d;
    logic                     empty, full, pop, push_ok, push_drop;
    logic [31:0]              status_word;

    logic                     unused_wb;
    assign unused_wb = ^{wb_addr_i, wb_sel_i, wb_data_i};

    assign reg_sel = wb_addr_i[3:2];
    // Blocking the request while ack is high keeps a held strobe to one ack.
    assign wb_req  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wb_rd   = wb_req & ~wb_we_i;
    assign wb_wr   = wb_req & wb_we_i;

    assign wb_ack_o  = ack_q & wb_cyc_i;
    assign wb_data_o = wb_ack_o ? rdata_q : '0;

    assign rx_s     = sync_q[1];
    assign bit_end  = divider_q + 32'd1;
    assign half_end = ((divider_q + 32'd2) >> 1) - 32'd1;

    assign empty       = (count_q == 4'd0);
    assign full        = (count_q == CountFull);
    assign status_word = {24'b0, count_q, frame_err_q, overrun_q, full, ~empty};

    always_comb begin
        ack_d     = wb_req;
        rdata_d   = '0;
        divider_d = divider_q;
        pop       = 1'b0;
        if (wb_rd) begin
            unique case (reg_sel)
                RegDivider: rdata_d = WB_DATA_WIDTH'(divider_q);
                RegData: begin
                    if (!empty) begin
                        rdata_d = WB_DATA_WIDTH'(mem_q[rptr_q]);
                        pop     = 1'b1;
                    end
                end
                RegStatus: rdata_d = WB_DATA_WIDTH'(status_word);
                RegSanity: rdata_d = WB_DATA_WIDTH'(SanityWord);
                default:   rdata_d = '0;
            endcase
        end
        if (wb_wr && reg_sel == RegDivider) begin
            divider_d = 32'(wb_data_i);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_push      = 1'b0;
        rx_frame_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = 32'd0;
                end
            end
            StStart: begin
                // Compares use >= so a shrinking DIVIDER mid-bit cannot overshoot.
                if (cnt_q >= half_end) begin
                    cnt_d     = 32'd0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StData: begin
                if (cnt_q >= bit_end) begin
                    cnt_d     = 32'd0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StStop: begin
                if (cnt_q >= bit_end) begin
                    cnt_d        = 32'd0;
                    rx_push      = rx_s;
                    rx_frame_err = ~rx_s;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok   = rx_push & (~full | pop);
        push_drop = rx_push & full & ~pop;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (push_ok) begin
            wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
        end
        count_d = count_q + {3'b0, push_ok} - {3'b0, pop};

        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (wb_wr && reg_sel == RegStatus) begin
            if (wb_data_i[2]) overrun_d = 1'b0;
            if (wb_data_i[3]) frame_err_d = 1'b0;
        end
        if (push_drop)    overrun_d   = 1'b1;
        if (rx_frame_err) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= 2'b11;
            state_q     <= StIdle;
            cnt_q       <= 32'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            divider_q   <= 32'd1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= 4'd0;
        end else begin
            sync_q      <= {sync_q[0], uart_rx_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            divider_q   <= divider_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx: serial frames in, Wishbone register reads out.
module tb_wb_uart_rx;

    localparam logic [31:0] AddrDivider = 32'h0;
    localparam logic [31:0] AddrData    = 32'h4;
    localparam logic [31:0] AddrStatus  = 32'h8;
    localparam logic [31:0] AddrSanity  = 32'hC;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic [31:0] wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic [31:0] wb_data_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_uart_rx dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .uart_rx_i (uart_rx_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_ack_o  (wb_ack_o),
        .wb_data_o (wb_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // All tasks start and end #1 after a rising edge.
    task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input bit hold, output logic [31:0] rdata);
        bit got_ack;
        wb_addr_i = addr;
        wb_we_i   = we;
        wb_data_i = wdata;
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        got_ack   = 1'b0;
        for (int i = 0; i < 8 && !got_ack; i++) begin
            @(posedge clk_i);
            #1;
            got_ack = wb_ack_o;
        end
        rdata = wb_data_o;
        check_eq("ack_seen", {31'b0, got_ack}, 32'd1);
        if (hold) begin
            @(posedge clk_i);
            #1;
            check_eq("ack_single", {31'b0, wb_ack_o}, 32'd0);
            check_eq("data_idle", wb_data_o, 32'd0);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        wb_xfer(addr, 1'b1, wdata, 1'b0, dummy);
    endtask

    task automatic wb_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(addr, 1'b0, 32'd0, 1'b0, rd);
        check_eq(tag, rd, exp);
    endtask

    task automatic drive_bit(input logic val, input int n);
        uart_rx_i = val;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int cpb);
        drive_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_bit(b[i], cpb);
        drive_bit(stop, cpb);
        drive_bit(1'b1, 2 * cpb);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b0;
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    logic [31:0] rd;
    logic [7:0]  partial;

    initial begin
        #2;
        check_eq("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check_eq("rst_data", wb_data_o, 32'd0);
        @(posedge clk_i);
        #1;
        do_reset();

        // Reset state and fixed registers
        wb_expect("rst_status", AddrStatus, 32'h00);
        wb_expect("rst_divider", AddrDivider, 32'd1);
        wb_xfer(AddrSanity, 1'b0, 32'd0, 1'b1, rd);
        check_eq("sanity", rd, 32'h0B0BA17E);
        wb_expect("data_empty", AddrData, 32'h00);
        wb_expect("status_after_empty_rd", AddrStatus, 32'h00);

        // Single byte at 3 clocks per bit
        send_byte(8'h55, 1'b1, 3);
        wb_expect("status_one", AddrStatus, 32'h11);
        wb_expect("data_55", AddrData, 32'h55);
        wb_expect("status_drained", AddrStatus, 32'h00);

        // Nine bytes into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 3);
        wb_expect("status_overrun", AddrStatus, 32'h87);
        for (int i = 1; i <= 8; i++) wb_expect("data_seq", AddrData, 32'(i));
        wb_expect("status_ovr_sticky", AddrStatus, 32'h04);
        wb_write(AddrStatus, 32'h4);
        wb_expect("status_ovr_clr", AddrStatus, 32'h00);

        // Bad stop bit
        send_byte(8'hA3, 1'b0, 3);
        wb_expect("status_frame", AddrStatus, 32'h08);
        wb_expect("data_after_frame", AddrData, 32'h00);
        wb_write(AddrStatus, 32'h8);
        wb_expect("status_frame_clr", AddrStatus, 32'h00);

        // Writes to read-only registers are ignored
        wb_write(AddrData, 32'hFF);
        wb_write(AddrSanity, 32'h12345678);
        wb_expect("sanity_after_wr", AddrSanity, 32'h0B0BA17E);
        wb_expect("status_after_wr", AddrStatus, 32'h00);

        // Glitch rejection at 11 clocks per bit, then a real frame
        wb_write(AddrDivider, 32'd9);
        wb_expect("divider_9", AddrDivider, 32'd9);
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 40);
        wb_expect("status_glitch", AddrStatus, 32'h00);
        send_byte(8'h96, 1'b1, 11);
        wb_expect("status_div9", AddrStatus, 32'h11);
        wb_expect("data_96", AddrData, 32'h96);

        // Reset during bit 4 of 0x3C at 6 clocks per bit
        wb_write(AddrDivider, 32'd4);
        partial = 8'h3C;
        drive_bit(1'b0, 6);
        for (int i = 0; i < 4; i++) drive_bit(partial[i], 6);
        drive_bit(partial[4], 3);
        do_reset();
        wb_expect("divider_after_rst", AddrDivider, 32'd1);
        wb_expect("status_after_rst", AddrStatus, 32'h00);
        send_byte(8'hC3, 1'b1, 3);
        wb_expect("status_c3", AddrStatus, 32'h11);
        wb_expect("data_c3", AddrData, 32'hC3);
        wb_expect("status_final", AddrStatus, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wb_uart_rx.md
WB_UART_RX -- requirements
Module: wb_uart_rx

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-003 SHALL have parameter WB_SEL_WIDTH, default WB_DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, max 8).
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port uart_rx_i  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have ports wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i  input  per parameters  Wishbone slave request.
REQ-009 SHALL have ports wb_ack_o  output  1 and wb_data_o  output  WB_DATA_WIDTH  Wishbone slave response.

Function
REQ-010 SHALL decode register by wb_addr_i[3:2]: 0 DIVIDER (RW), 1 DATA (RO, read pops), 2 STATUS (RO, W1C sticky bits), 3 SANITY (RO, 32'h0B0BA17E).
REQ-011 SHALL assert internal ack one cycle after cyc&stb, for exactly one cycle per access; wb_ack_o = ack & wb_cyc_i; no second ack while cyc&stb remain high in the ack cycle.
REQ-012 SHALL drive wb_data_o with read data in the ack cycle, 0 at all other times.
REQ-013 STATUS SHALL be: bit0 not-empty, bit1 full, bit2 overrun (sticky), bit3 frame error (sticky), bits[7:4] FIFO count, others 0.
REQ-014 Writing STATUS with bit2/bit3 set SHALL clear the respective sticky bit; writes to DATA/SANITY SHALL be acked and ignored.
REQ-015 DATA read SHALL return {24'b0, head byte} and pop; DATA read when empty SHALL return 0, no pop, FIFO unchanged.
REQ-016 uart_rx_i SHALL pass a 2-flop synchronizer (flops reset to 1) before any use.
REQ-017 Bit period SHALL be DIVIDER+2 clocks (matching the transmitter); half = (DIVIDER+2)>>1.
REQ-018 FSM states: IDLE, START, DATA, STOP; bit counter cnt (32-bit) and bit index (3-bit).
REQ-019 IDLE: synced line 0 -> START, cnt=0.
REQ-020 START: at cnt==half-1, line 0 -> DATA, cnt=0; line 1 -> IDLE (glitch rejected, no status change).
REQ-021 DATA: at cnt==DIVIDER+1 sample line, shift in LSB first, cnt=0; after 8th bit -> STOP.
REQ-022 STOP: at cnt==DIVIDER+1: line 1 -> push byte, line 0 -> set frame error, discard byte; both -> IDLE.
REQ-023 Push when full and no pop same cycle SHALL drop byte, set overrun; FIFO contents unchanged.
REQ-024 Simultaneous push and pop SHALL both take effect: count unchanged, no overrun even if full.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-026 DIVIDER write SHALL take effect on the next counter compare, including mid-frame (no frame restart).

Reset
REQ-027 rst_i SHALL asynchronously force: FSM IDLE, cnt 0, DIVIDER 1, FIFO empty, sticky bits 0, synchronizer 1, ack 0, wb_data_o 0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; after release, next falling edge starts a new frame.

Verification
REQ-029 DIVIDER=1 (3 clk/bit), send 0x55 with stop 1 -> STATUS 0x11; DATA read 0x55; STATUS then 0x00.
REQ-030 DIVIDER=1, send 9 bytes 0x01..0x09 without reads -> STATUS 0x87; 8 DATA reads return 0x01..0x08; write STATUS 0x4 -> bit2 clear.
REQ-031 Send 0xA3 with stop bit 0 -> STATUS 0x08, FIFO empty; write STATUS 0x8 -> STATUS 0x00.
REQ-032 DIVIDER=9, single-clock low pulse on uart_rx_i -> no push, STATUS 0x00, FSM back in IDLE.
REQ-033 Assert rst_i during bit 4 of 0x3C; release; send 0xC3 -> only 0xC3 read, DIVIDER reads 1.
REQ-034 Read SANITY -> 32'h0B0BA17E with one-cycle ack; read DATA when empty -> 0, count stays 0.
